regfile_mp: RTL and testbench

Parametrised multi-port integer register file, the next-generation register file for the RV32I core. It provides NUM_RD combinational read ports and two prioritised write ports (port A for ALU writeback, port B for load writeback), with optional write-through bypass and a hardwired zero register. It also adds a per-register pending scoreboard: registers are set at issue and cleared at writeback, so the hazard unit can stall on busy sources. It sits between decode/issue and the writeback stages.

---
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass, hardwired zero
// register and a per-register pending scoreboard for hazard detection.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wa_en,
  input  logic [AW-1:0]          wa_addr,
  input  logic [XLEN-1:0]        wa_data,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   flush,
  output logic [AW:0]            pend_cnt
);

  localparam int unsigned NREGS = 2 ** AW;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;

  logic wa_ok, wb_ok, iss_ok;

  // Address 0 is a sink when the zero register is hardwired.
  assign wa_ok  = wa_en  && !((ZERO_REG != 0) && (wa_addr  == '0));
  assign wb_ok  = wb_en  && !((ZERO_REG != 0) && (wb_addr  == '0));
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + (AW+1)'(v[i]);
    end
    return cnt;
  endfunction

  // Register write next-state; port B is applied last so it wins a collision.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wa_ok) regs_d[wa_addr] = wa_data;
    if (wb_ok) regs_d[wb_addr] = wb_data;
  end

  // Scoreboard next-state: flush, then issue-set beats writeback-clear.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wa_en) pend_d[wa_addr] = 1'b0;
      if (wb_en) pend_d[wb_addr] = 1'b0;
      if (iss_ok) pend_d[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
    pend_cnt_d = popcount(pend_d);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  // Combinational read ports with optional forwarding; forced quiet in reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0]   addr;
      logic            wa_hit, wb_hit, iss_hit;
      logic [XLEN-1:0] data;
      logic            busy;
      addr    = rd_addr[k*AW +: AW];
      wa_hit  = wa_en && (wa_addr == addr);
      wb_hit  = wb_en && (wb_addr == addr);
      iss_hit = iss_en && (iss_addr == addr);
      data    = regs_q[addr];
      busy    = pend_q[addr];
      if (BYPASS != 0) begin
        if (wb_hit) begin
          data = wb_data;
        end else if (wa_hit) begin
          data = wa_data;
        end
        // Forwarded data clears the hazard unless a younger producer issues now.
        if ((wa_hit || wb_hit) && !iss_hit) busy = 1'b0;
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
      if (!rst_n) begin
        data = '0;
        busy = 1'b0;
      end
      rd_data[k*XLEN +: XLEN] = data;
      rd_busy[k]              = busy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: stimulus pushes expected observations, a negedge monitor
// pops and compares them. A BYPASS=0 instance shares all inputs.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic              wa_en, wb_en, iss_en, flush;
  logic [AW-1:0]     wa_addr, wb_addr, iss_addr;
  logic [XLEN-1:0]   wa_data, wb_data;

  logic [NRD*XLEN-1:0] data_a, data_b;
  logic [NRD-1:0]      busy_a, busy_b;
  logic [AW:0]         cnt_a, cnt_b;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .AW(AW), .NUM_RD(NRD), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(data_a), .rd_busy(busy_a),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .pend_cnt(cnt_a)
  );

  regfile_mp #(.XLEN(XLEN), .AW(AW), .NUM_RD(NRD), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(data_b), .rd_busy(busy_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .pend_cnt(cnt_b)
  );

  typedef enum int {
    SelD0, SelD1, SelB0, SelB1, SelCnt, SelNbD0, SelNbB0, SelNbCnt
  } sel_e;

  typedef struct {
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      SelD0:    return data_a[31:0];
      SelD1:    return data_a[63:32];
      SelB0:    return {31'b0, busy_a[0]};
      SelB1:    return {31'b0, busy_a[1]};
      SelCnt:   return {26'b0, cnt_a};
      SelNbD0:  return data_b[31:0];
      SelNbB0:  return {31'b0, busy_b[0]};
      default:  return {26'b0, cnt_b};
    endcase
  endfunction

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t        e;
        logic [31:0] got;
        e   = q.pop_front();
        got = observe(e.sel);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input sel_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.sel  = s;
    e.exp  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; iss_en = 0; flush = 0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    idle();
    wa_addr = 0; wb_addr = 0; iss_addr = 0; wa_data = 0; wb_data = 0;
    set_rd(0, 0);

    // 1: writes during reset are ignored, outputs quiet
    wa_en = 1; wa_addr = 3; wa_data = 32'hDEADBEEF; set_rd(3, 3);
    #1;
    expect_v(SelD0, 32'h0, "rst_data_during");
    expect_v(SelB0, 32'h0, "rst_busy_during");
    cyc(); cyc();
    rst_n = 1; idle();
    expect_v(SelD0, 32'h0, "rst_reg3");
    expect_v(SelB0, 32'h0, "rst_busy");
    expect_v(SelCnt, 32'h0, "rst_cnt");

    // 2: dual-port collision, port B wins
    cyc();
    wa_en = 1; wa_addr = 7; wa_data = 32'h11111111;
    wb_en = 1; wb_addr = 7; wb_data = 32'h22222222; set_rd(7, 7);
    expect_v(SelD0, 32'h22222222, "coll_byp0");
    expect_v(SelD1, 32'h22222222, "coll_byp1");
    expect_v(SelNbD0, 32'h0, "coll_nobyp_old");
    cyc(); idle();
    expect_v(SelD0, 32'h22222222, "coll_reg7");
    expect_v(SelNbD0, 32'h22222222, "coll_nobyp_reg7");

    // 3: zero register ignores writes and issue
    cyc();
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; set_rd(0, 0);
    expect_v(SelD0, 32'h0, "zero_data_byp");
    expect_v(SelB0, 32'h0, "zero_busy");
    cyc(); idle();
    expect_v(SelD0, 32'h0, "zero_data_after");
    expect_v(SelCnt, 32'h0, "zero_cnt");

    // 4: scoreboard lifecycle on reg5
    cyc();
    iss_en = 1; iss_addr = 5; set_rd(5, 0);
    expect_v(SelB0, 32'h0, "life_busy_issue_cycle");
    cyc(); idle();
    expect_v(SelB0, 32'h1, "life_busy");
    expect_v(SelCnt, 32'h1, "life_cnt1");
    expect_v(SelNbB0, 32'h1, "life_nb_busy");
    cyc();
    wa_en = 1; wa_addr = 5; wa_data = 32'hA5;
    expect_v(SelB0, 32'h0, "life_wb_busy");
    expect_v(SelD0, 32'hA5, "life_wb_data");
    expect_v(SelNbB0, 32'h1, "life_nb_wb_busy");
    expect_v(SelNbD0, 32'h0, "life_nb_wb_data");
    expect_v(SelCnt, 32'h1, "life_wb_cnt");
    cyc(); idle();
    expect_v(SelCnt, 32'h0, "life_cnt0");
    expect_v(SelD0, 32'hA5, "life_reg5");

    // 5: set beats clear, then flush beats issue
    cyc();
    iss_en = 1; iss_addr = 9; set_rd(9, 4);
    cyc();
    iss_en = 1; iss_addr = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    expect_v(SelB0, 32'h1, "race_busy_reissue");
    expect_v(SelD0, 32'h99, "race_data_fwd");
    expect_v(SelCnt, 32'h1, "race_cnt_pre");
    cyc(); idle();
    iss_en = 1; iss_addr = 1;
    expect_v(SelB0, 32'h1, "race_still_pending");
    expect_v(SelCnt, 32'h1, "race_cnt_post");
    cyc(); iss_addr = 2;
    expect_v(SelCnt, 32'h2, "race_cnt2");
    cyc(); iss_addr = 3;
    expect_v(SelCnt, 32'h3, "race_cnt3");
    cyc(); iss_addr = 4; flush = 1;
    expect_v(SelCnt, 32'h4, "race_cnt4");
    expect_v(SelNbCnt, 32'h4, "race_nb_cnt4");
    cyc(); idle();
    expect_v(SelCnt, 32'h0, "flush_cnt");
    expect_v(SelB1, 32'h0, "flush_reg4");
    expect_v(SelB0, 32'h0, "flush_reg9");

    // 6: no-bypass build returns pre-edge value
    cyc();
    wa_en = 1; wa_addr = 6; wa_data = 32'h1234; set_rd(6, 6);
    expect_v(SelNbD0, 32'h0, "nb_old");
    expect_v(SelD0, 32'h1234, "byp_new");
    cyc(); idle();
    expect_v(SelNbD0, 32'h1234, "nb_new");

    // Mid-operation reset clears everything immediately
    iss_en = 1; iss_addr = 10;
    cyc(); idle();
    expect_v(SelCnt, 32'h1, "pre_rst_cnt");
    cyc();
    #2 rst_n = 0;
    #1;
    expect_v(SelD0, 32'h0, "mid_rst_data");
    expect_v(SelCnt, 32'h0, "mid_rst_cnt");
    cyc();
    rst_n = 1;
    expect_v(SelD0, 32'h0, "post_rst_reg6");
    expect_v(SelNbD0, 32'h0, "post_rst_nb_reg6");
    expect_v(SelCnt, 32'h0, "post_rst_cnt");

    cyc();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
